// File: rtl/ef_bus_arbiter.sv
// ef_bus_arbiter: round-robin arbiter and setup/strobe/hold sequencer for the
// shared Flash/Ethernet external bus. Requester 0 = CFI flash, 1 = LAN91C111.
// Optional feature macro: EF_ARB_TURNAROUND_EN inserts one idle TURN cycle
// whenever consecutive accesses target different devices.
// Bus controls decode directly from registered state, so reset clears them
// asynchronously; address and write data stay registered and hold in IDLE.
module ef_bus_arbiter #(
    parameter int AW        = 23,
    parameter int DW        = 32,
    parameter int FL_SETUP  = 2,
    parameter int FL_STROBE = 6,
    parameter int FL_HOLD   = 1,
    parameter int EN_SETUP  = 1,
    parameter int EN_STROBE = 4,
    parameter int EN_HOLD   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdat,
    input  logic [3:0]    m0_be,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdat,
    input  logic [3:0]    m1_be,
    output logic          m1_ack,
    output logic [DW-1:0] rdat,
    output logic [AW-1:0] ef_a,
    output logic [DW-1:0] ef_d_o,
    output logic          ef_d_oe,
    input  logic [DW-1:0] ef_d_i,
    output logic          flash_ce_n,
    output logic          flash_oe_n,
    output logic          flash_we_n,
    output logic          enet_rd_n,
    output logic          enet_wr_n,
    output logic [3:0]    enet_be_n
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
`ifdef EF_ARB_TURNAROUND_EN
    localparam logic [2:0] S_TURN   = 3'd4;
`endif

    // Strobe/hold of 0 are illegal; hardware runs them as a single cycle.
    localparam logic [3:0] FL_S = 4'(FL_SETUP);
    localparam logic [3:0] FL_T = (FL_STROBE == 0) ? 4'd1 : 4'(FL_STROBE);
    localparam logic [3:0] FL_H = (FL_HOLD   == 0) ? 4'd1 : 4'(FL_HOLD);
    localparam logic [3:0] EN_S = 4'(EN_SETUP);
    localparam logic [3:0] EN_T = (EN_STROBE == 0) ? 4'd1 : 4'(EN_STROBE);
    localparam logic [3:0] EN_H = (EN_HOLD   == 0) ? 4'd1 : 4'(EN_HOLD);

    function automatic logic [3:0] setup_of(input logic g);
        return g ? EN_S : FL_S;
    endfunction

    function automatic logic [3:0] strobe_of(input logic g);
        return g ? EN_T : FL_T;
    endfunction

    function automatic logic [3:0] hold_of(input logic g);
        return g ? EN_H : FL_H;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [DW-1:0] rdat_q, rdat_d;
`ifdef EF_ARB_TURNAROUND_EN
    logic          prev_vld_q, prev_vld_d;
`endif

    logic          pick, g_sel, last_cnt;
    logic [2:0]    first_st;
    logic [3:0]    first_cnt;
    logic          act, strb;

    // Next-state: arbitration in IDLE, then counted setup/strobe/hold phases.
    always_comb begin
        pick      = (m0_req & m1_req) ? ~last_q : m1_req;
        g_sel     = (state_q == S_IDLE) ? pick : gnt_q;
        first_st  = (setup_of(g_sel) != 4'd0) ? S_SETUP : S_STROBE;
        first_cnt = (setup_of(g_sel) != 4'd0) ? setup_of(g_sel) : strobe_of(g_sel);
        last_cnt  = (cnt_q <= 4'd1);
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        be_d      = be_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
`ifdef EF_ARB_TURNAROUND_EN
        prev_vld_d = prev_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    gnt_d  = pick;
                    last_d = pick;
                    we_d   = pick ? m1_we   : m0_we;
                    be_d   = pick ? m1_be   : m0_be;
                    adr_d  = pick ? m1_adr  : m0_adr;
                    wdat_d = pick ? m1_wdat : m0_wdat;
`ifdef EF_ARB_TURNAROUND_EN
                    prev_vld_d = 1'b1;
                    if (prev_vld_q && (pick != last_q)) begin
                        state_d = S_TURN;
                    end else begin
                        state_d = first_st;
                        cnt_d   = first_cnt;
                    end
`else
                    state_d = first_st;
                    cnt_d   = first_cnt;
`endif
                end
            end
`ifdef EF_ARB_TURNAROUND_EN
            S_TURN: begin
                state_d = first_st;
                cnt_d   = first_cnt;
            end
`endif
            S_SETUP: begin
                if (last_cnt) begin
                    state_d = S_STROBE;
                    cnt_d   = strobe_of(gnt_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (last_cnt) begin
                    state_d = S_HOLD;
                    cnt_d   = hold_of(gnt_q);
                    rdat_d  = ef_d_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (last_cnt) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset kills any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
`ifdef EF_ARB_TURNAROUND_EN
            prev_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            be_q    <= be_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
`ifdef EF_ARB_TURNAROUND_EN
            prev_vld_q <= prev_vld_d;
`endif
        end
    end

    // Pin decode: chip-select over the whole access, strobe only in STROBE.
    always_comb begin
        act        = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
        strb       = (state_q == S_STROBE);
        flash_ce_n = ~(act & ~gnt_q);
        flash_oe_n = ~(strb & ~gnt_q & ~we_q);
        flash_we_n = ~(strb & ~gnt_q & we_q);
        enet_rd_n  = ~(strb & gnt_q & ~we_q);
        enet_wr_n  = ~(strb & gnt_q & we_q);
        enet_be_n  = (act & gnt_q) ? ~be_q : 4'hF;
        ef_d_oe    = act & we_q;
        m0_ack     = (state_q == S_HOLD) & last_cnt & ~gnt_q;
        m1_ack     = (state_q == S_HOLD) & last_cnt & gnt_q;
    end

    assign ef_a   = adr_q;
    assign ef_d_o = wdat_q;
    assign rdat   = rdat_q;

`ifndef SYNTHESIS
    // Timing parameters out of range are a configuration error.
    always @(posedge clk) begin
        assert (FL_STROBE > 0 && FL_HOLD > 0 && EN_STROBE > 0 && EN_HOLD > 0 &&
                FL_SETUP <= 15 && FL_STROBE <= 15 && FL_HOLD <= 15 &&
                EN_SETUP <= 15 && EN_STROBE <= 15 && EN_HOLD <= 15);
    end
`endif

endmodule

// File: tb/tb_ef_bus_arbiter.sv
// Directed bench for ef_bus_arbiter with default timing (flash 2/6/1,
// Ethernet 1/4/1). Inputs change and outputs are sampled on the falling edge.
module tb_ef_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [22:0] m0_adr = '0, m1_adr = '0;
    logic [31:0] m0_wdat = '0, m1_wdat = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        m0_ack, m1_ack;
    logic [31:0] rdat, ef_d_o;
    logic [31:0] ef_d_i = '0;
    logic [22:0] ef_a;
    logic        ef_d_oe, flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n;
    logic [3:0]  enet_be_n;
    logic [7:0]  ctl;
    int          n_vec = 0, n_err = 0;

    ef_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_be(m0_be), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_be(m1_be), .m1_ack(m1_ack),
        .rdat(rdat), .ef_a(ef_a), .ef_d_o(ef_d_o), .ef_d_oe(ef_d_oe), .ef_d_i(ef_d_i),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
        .enet_rd_n(enet_rd_n), .enet_wr_n(enet_wr_n), .enet_be_n(enet_be_n)
    );

    always #5 clk = ~clk;

    assign ctl = {flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n, ef_d_oe, m0_ack, m1_ack};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns on the falling edge where the chosen ack is high.
    task automatic wait_ack(input logic who, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who ? m1_ack : m0_ack) && n < 60);
        if (!(who ? m1_ack : m0_ack)) chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    // Counts fully idle cycles before either device's controls go active.
    task automatic count_gap(input string tag, input int exp);
        int g = 0;
        @(negedge clk);
        while (flash_ce_n && enet_be_n == 4'hF && !ef_d_oe && g < 10) begin
            g++;
            @(negedge clk);
        end
        chk(tag, g, exp);
    endtask

    int exp_cyc[4];
    logic exp_who[4];

    initial begin
`ifdef EF_ARB_TURNAROUND_EN
        exp_cyc = '{9, 17, 28, 36};
`else
        exp_cyc = '{9, 16, 26, 33};
`endif
        exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("rst ctl", ctl, 8'b1111_1000);
        chk("rst be_n", enet_be_n, 4'hF);
        chk("rst ef_a", ef_a, 0);
        chk("rst ef_d_o", ef_d_o, 0);
        chk("rst rdat", rdat, 0);

        // Flash read: CE 1..9, OE 3..8, ack 9; data changes just before the capture edge
        m0_adr = 23'h012345; m0_we = 1'b0; m0_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("fl_rd c%0d", i), ctl,
                {1'b0, (i >= 3 && i <= 8) ? 1'b0 : 1'b1, 3'b111, 1'b0, (i == 9), 1'b0});
            if (i == 1) chk("fl_rd adr", ef_a, 32'h012345);
            if (i == 8) ef_d_i = 32'hDEADBEEF;
            if (i == 9) begin
                chk("fl_rd rdat", rdat, 32'hDEADBEEF);
                ef_d_i = '0;
                m0_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("fl_rd idle ctl", ctl, 8'b1111_1000);
        chk("fl_rd idle adr", ef_a, 32'h012345);

        // Ethernet write: BE_n=1100, OE 1..6, WR 2..5, ack 6
        do_reset();
        m1_adr = 23'h000100; m1_we = 1'b1; m1_be = 4'b0011; m1_wdat = 32'h12345678; m1_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("en_wr c%0d", i), ctl,
                {4'b1111, (i >= 2 && i <= 5) ? 1'b0 : 1'b1, 1'b1, 1'b0, (i == 6)});
            chk($sformatf("en_wr be c%0d", i), enet_be_n, 4'b1100);
            chk($sformatf("en_wr d c%0d", i), ef_d_o, 32'h12345678);
            if (i == 6) m1_req = 1'b0;
        end
        @(negedge clk);
        chk("en_wr idle be", enet_be_n, 4'hF);

        // Both requesting from reset: alternating grants at fixed cycles
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0; m1_be = 4'b1010;
        m0_req = 1'b1; m1_req = 1'b1;
        begin
            int cyc = 0, nack = 0;
            while (nack < 4 && cyc < 80) begin
                @(negedge clk);
                cyc++;
                if (m0_ack && m1_ack) chk("alt dual ack", 32'd1, 32'd0);
                if (m0_ack || m1_ack) begin
                    chk($sformatf("alt who%0d", nack), m1_ack, exp_who[nack]);
                    chk($sformatf("alt cyc%0d", nack), cyc, exp_cyc[nack]);
                    if (m1_ack) chk("alt en be", {flash_ce_n, enet_be_n}, 5'b1_0101);
                    else        chk("alt fl ce", {flash_ce_n, enet_be_n}, 5'b0_1111);
                    nack++;
                end
            end
            chk("alt count", nack, 4);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Reset during STROBE of a flash write
        do_reset();
        m0_adr = 23'h0000AA; m0_we = 1'b1; m0_wdat = 32'hAAAA5555; m0_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid we_n", {flash_ce_n, flash_we_n, ef_d_oe}, 3'b001);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid ctl", ctl, 8'b1111_1000);
        chk("rst_mid ef_a", ef_a, 0);
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int acks = 0;
            repeat (12) begin
                @(negedge clk);
                if (m0_ack || m1_ack) acks++;
            end
            chk("rst_mid no ack", acks, 0);
        end

        // Idle gap between accesses: device switch vs same device
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0; m1_be = 4'hF;
        m0_req = 1'b1;
        wait_ack(1'b0, "gap fl");
        m0_req = 1'b0; m1_req = 1'b1;
`ifdef EF_ARB_TURNAROUND_EN
        count_gap("gap fl->en", 2);
`else
        count_gap("gap fl->en", 1);
`endif
        wait_ack(1'b1, "gap en");
        m1_req = 1'b0; m0_req = 1'b1;
        wait_ack(1'b0, "gap fl2");
        count_gap("gap fl->fl", 1);
        wait_ack(1'b0, "gap fl3");
        m0_req = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
